// File: rtl/alu_seq_pkg.sv
// Purpose: shared opcodes, FSM state encoding and opcode-class helpers for alu_seq_md.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_NOR   = 4'h4;
  localparam logic [3:0] OP_SLT   = 4'h5;
  localparam logic [3:0] OP_SLTU  = 4'h6;
  localparam logic [3:0] OP_SLL   = 4'h7;
  localparam logic [3:0] OP_SRL   = 4'h8;
  localparam logic [3:0] OP_SRA   = 4'h9;
  localparam logic [3:0] OP_MULT  = 4'hA;
  localparam logic [3:0] OP_MULTU = 4'hB;
  localparam logic [3:0] OP_DIV   = 4'hC;
  localparam logic [3:0] OP_DIVU  = 4'hD;
  localparam logic [3:0] OP_MFHI  = 4'hE;
  localparam logic [3:0] OP_MFLO  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  // Multi-cycle ops handled by the iterative engine.
  function automatic logic is_md(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Purpose: iterative shift-add multiplier / restoring divider on magnitudes, sign-corrected outputs.
// Latency: WIDTH iteration cycles after start (divide-by-zero: results ready right after start).
// Backpressure: none; start is only pulsed by the top while idle, done flags the final iteration.
module alu_md_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW:0]       cnt;
  logic [WIDTH-1:0]   acc;      // high product half / partial remainder
  logic [WIDTH-1:0]   q;        // multiplier bits / dividend-quotient shift register
  logic [WIDTH-1:0]   opnd;     // multiplicand / divisor magnitude
  logic               div_mode;
  logic               neg_lo;   // negate product (mul) or quotient (div)
  logic               neg_hi;   // negate remainder (div)
  logic               dz_r;

  logic               signed_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, rem_sh, rem_diff;
  logic [WIDTH-1:0]   acc_nx, q_nx;
  logic [2*WIDTH-1:0] prod, prod_s;

  // Operand magnitudes for the signed variants.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;
  end

  // One shift-add or one restoring-divide step.
  always_comb begin
    add_sum  = {1'b0, acc} + (q[0] ? {1'b0, opnd} : '0);
    rem_sh   = {acc, q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    if (div_mode) begin
      if (!rem_diff[WIDTH]) begin
        acc_nx = rem_diff[WIDTH-1:0];
        q_nx   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = rem_sh[WIDTH-1:0];
        q_nx   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nx = add_sum[WIDTH:1];
      q_nx   = {add_sum[0], q[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitudes.
  always_comb begin
    prod   = {acc, q};
    prod_s = neg_lo ? -prod : prod;
    if (div_mode) begin
      hi = neg_hi ? -acc : acc;
      lo = neg_lo ? -q : q;
    end else begin
      hi = prod_s[2*WIDTH-1:WIDTH];
      lo = prod_s[WIDTH-1:0];
    end
    done = (cnt == (SHW+1)'(1));
    dz   = dz_r;
  end

  // Load on start, then iterate while the counter is non-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      dz_r     <= 1'b0;
    end else if (start) begin
      div_mode <= is_div(op);
      opnd     <= mag_b;
      if (is_div(op) && (b == '0)) begin
        // Divide by zero: results are ready without iterating.
        cnt    <= '0;
        acc    <= a;
        q      <= '1;
        neg_lo <= 1'b0;
        neg_hi <= 1'b0;
        dz_r   <= 1'b1;
      end else begin
        cnt    <= (SHW+1)'(WIDTH);
        acc    <= '0;
        q      <= mag_a;
        neg_lo <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_hi <= signed_op && a[WIDTH-1];
        dz_r   <= 1'b0;
      end
    end else if (cnt != '0) begin
      acc <= acc_nx;
      q   <= q_nx;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_md.sv
// Purpose: MIPS execute-stage ALU with single-cycle ops plus iterative MULT/DIV and HI/LO.
// Latency: 1 cycle single-cycle ops; WIDTH+2 for MULT/DIV; 2 for divide-by-zero.
// Backpressure: in_ready high only in IDLE; in_valid while not ready is ignored, not queued.
module alu_seq_md
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control_in,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             ZERO,
  output logic             OVF,
  output logic             DZ,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             accept, md_start;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic [SHW-1:0]   shamt;
  logic             eng_done, eng_dz;
  logic [WIDTH-1:0] eng_hi, eng_lo;

  assign in_ready = (state == ST_IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_valid & in_ready;
  assign md_start = accept & is_md(control_in);

  alu_md_iter #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .rst   (reset),
    .start (md_start),
    .op    (control_in),
    .a     (in1),
    .b     (in2),
    .done  (eng_done),
    .hi    (eng_hi),
    .lo    (eng_lo),
    .dz    (eng_dz)
  );

  // Single-cycle result and signed-overflow flag.
  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    shamt   = in2[SHW-1:0];
    case (control_in)
      OP_ADD: begin
        res     = in1 + in2;
        res_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (res[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        res     = in1 - in2;
        res_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (res[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND:  res = in1 & in2;
      OP_OR:   res = in1 | in2;
      OP_NOR:  res = ~(in1 | in2);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_SLL:  res = in1 << shamt;
      OP_SRL:  res = in1 >> shamt;
      OP_SRA:  res = $signed(in1) >>> shamt;
      OP_MFHI: res = hi_r;
      OP_MFLO: res = lo_r;
      default: res = '0;
    endcase
  end

  // Control FSM with registered result, flags and HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      out       <= '0;
      ZERO      <= 1'b1;
      OVF       <= 1'b0;
      DZ        <= 1'b0;
      out_valid <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_md(control_in)) begin
              if (is_div(control_in) && (in2 == '0)) state <= ST_FIX;
              else if (is_div(control_in))           state <= ST_DIV;
              else                                   state <= ST_MUL;
            end else begin
              out       <= res;
              ZERO      <= (res == '0);
              OVF       <= res_ovf;
              DZ        <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (eng_done) state <= ST_FIX;
        end
        ST_FIX: begin
          hi_r      <= eng_hi;
          lo_r      <= eng_lo;
          out       <= eng_lo;
          ZERO      <= (eng_lo == '0);
          OVF       <= 1'b0;
          DZ        <= eng_dz;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_md.sv
// Purpose: self-checking bench for alu_seq_md (WIDTH=32 randomized + directed, WIDTH=8 directed).
// Latency: checks exact accept-to-out_valid cycle counts against the reference model.
// Backpressure: drives junk requests while busy; they must be ignored.
module tb_alu_seq_md;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  ctl;
  logic [31:0] in1, in2;
  logic        in_ready, out_valid, zero_f, ovf_f, dz_f, busy;
  logic [31:0] out;

  logic        rst8, iv8, rdy8, ov8, z8, f8, d8, bsy8;
  logic [3:0]  ctl8;
  logic [7:0]  a8, b8, o8;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] hi_m, lo_m;

  always #5 clk = ~clk;

  alu_seq_md #(.WIDTH(32)) dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .control_in(ctl), .in1(in1), .in2(in2), .out_valid(out_valid), .out(out),
    .ZERO(zero_f), .OVF(ovf_f), .DZ(dz_f), .busy(busy)
  );

  alu_seq_md #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .in_valid(iv8), .in_ready(rdy8),
    .control_in(ctl8), .in1(a8), .in2(b8), .out_valid(ov8), .out(o8),
    .ZERO(z8), .OVF(f8), .DZ(d8), .busy(bsy8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural reference: exact-integer arithmetic, updates model HI/LO.
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ovf, output logic dz,
                                 output int lat);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          t;
    longint unsigned u;
    r = 32'h0; ovf = 1'b0; dz = 1'b0; lat = 1;
    case (op)
      4'h0: begin t = sa + sb; r = a + b; ovf = (t != longint'($signed(r))); end
      4'h1: begin t = sa - sb; r = a - b; ovf = (t != longint'($signed(r))); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = ~(a | b);
      4'h5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'h6: r = (ua < ub) ? 32'd1 : 32'd0;
      4'h7: r = a << b[4:0];
      4'h8: r = a >> b[4:0];
      4'h9: r = 32'(sa >>> b[4:0]);
      4'hA: begin t = sa * sb; {hi_m, lo_m} = t; r = lo_m; lat = 34; end
      4'hB: begin u = ua * ub; {hi_m, lo_m} = u; r = lo_m; lat = 34; end
      4'hC, 4'hD: begin
        if (b == 32'h0) begin
          hi_m = a; lo_m = 32'hFFFF_FFFF; dz = 1'b1; lat = 2;
        end else if (op == 4'hC) begin
          lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); lat = 34;
        end else begin
          lo_m = 32'(ua / ub); hi_m = 32'(ua % ub); lat = 34;
        end
        r = lo_m;
      end
      4'hE: r = hi_m;
      default: r = lo_m;
    endcase
  endfunction

  // Issue one op from idle, wait for its result while poking junk requests, check everything.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] er;
    logic        eo, ed;
    int          el, lat, rdy_hits;
    ref_op(op, a, b, er, eo, ed, el);
    @(negedge clk);
    ctl = op; in1 = a; in2 = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in1 = $urandom; in2 = $urandom;
    lat = 1; rdy_hits = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_hits++;
      in_valid = 1'($urandom_range(0, 1));
      ctl = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(el));
    chk({tag, " out"},     64'(out), 64'(er));
    chk({tag, " ZERO"},    64'(zero_f), 64'(er == 32'h0));
    chk({tag, " OVF"},     64'(ovf_f), 64'(eo));
    chk({tag, " DZ"},      64'(dz_f), 64'(ed));
    if (el > 1) chk({tag, " ready while busy"}, 64'(rdy_hits), 64'd0);
    @(negedge clk);
    chk({tag, " pulse"}, 64'(out_valid), 64'd0);
    chk({tag, " held"},  64'(out), 64'(er));
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_out, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    ctl8 = op; a8 = a; b8 = b; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " out"},     64'(o8), 64'(exp_out));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    rst = 1'b1; rst8 = 1'b1;
    in_valid = 1'b0; ctl = 4'h0; in1 = 32'h0; in2 = 32'h0;
    iv8 = 1'b0; ctl8 = 4'h0; a8 = 8'h0; b8 = 8'h0;
    hi_m = 32'h0; lo_m = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset out",       64'(out), 64'd0);
    chk("reset ZERO",      64'(zero_f), 64'd1);
    chk("reset OVF",       64'(ovf_f), 64'd0);
    chk("reset DZ",        64'(dz_f), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready",  64'(in_ready), 64'd1);
    chk("reset busy",      64'(busy), 64'd0);
    rst = 1'b0; rst8 = 1'b0;

    // Directed cases.
    run_op(4'h0, 32'h7FFF_FFFF, 32'h1, "add ovf");
    run_op(4'h1, 32'd5, 32'd5, "sub zero");
    run_op(4'hA, 32'hFFFF_FFFD, 32'd7, "mult -3*7");
    run_op(4'hE, 32'h0, 32'h0, "mfhi after mult");
    run_op(4'hF, 32'h0, 32'h0, "mflo after mult");
    run_op(4'hC, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    run_op(4'hE, 32'h0, 32'h0, "mfhi after div");
    run_op(4'hD, 32'd7, 32'd0, "divu by zero");
    run_op(4'hE, 32'h0, 32'h0, "mfhi after dz");
    run_op(4'hC, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
    run_op(4'hE, 32'h0, 32'h0, "mfhi after min/-1");
    run_op(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");
    run_op(4'hE, 32'h0, 32'h0, "mfhi after multu");

    // Back-to-back single-cycle ops.
    @(negedge clk);
    in_valid = 1'b1; ctl = 4'h2; in1 = 32'hF0F0_1234; in2 = 32'h0FF0_FF00;
    @(negedge clk);
    chk("b2b and valid", 64'(out_valid), 64'd1);
    chk("b2b and out",   64'(out), 64'h0000_0000_00F0_1200);
    ctl = 4'h7; in1 = 32'h1234_5678; in2 = 32'd4;
    @(negedge clk);
    chk("b2b sll valid", 64'(out_valid), 64'd1);
    chk("b2b sll out",   64'(out), 64'h0000_0000_2345_6780);
    ctl = 4'h9; in1 = 32'h8000_0000; in2 = 32'd31;
    @(negedge clk);
    chk("b2b sra valid", 64'(out_valid), 64'd1);
    chk("b2b sra out",   64'(out), 64'h0000_0000_FFFF_FFFF);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b end", 64'(out_valid), 64'd0);

    // Reset in the middle of a MULTU.
    ctl = 4'hB; in1 = 32'd1234567; in2 = 32'd7654321; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("midop busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hi_m = 32'h0; lo_m = 32'h0;
    chk("midop reset ready", 64'(in_ready), 64'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    chk("midop no out_valid", 64'(pulses), 64'd0);
    run_op(4'hE, 32'h0, 32'h0, "mfhi after abort");
    run_op(4'hF, 32'h0, 32'h0, "mflo after abort");

    // Randomized stream against the reference model.
    for (int i = 0; i < 200; i++) begin
      rop = 4'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(0, 40));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op(rop, ra, rb, "random");
    end

    // Narrow instance.
    run8(4'hB, 8'hFF, 8'hFF, 8'h01, 10, "w8 multu");
    run8(4'hE, 8'h00, 8'h00, 8'hFE, 1, "w8 mfhi");
    run8(4'h6, 8'h80, 8'h01, 8'h00, 1, "w8 sltu");
    run8(4'h5, 8'h80, 8'h01, 8'h01, 1, "w8 slt");
    run8(4'hC, 8'hF9, 8'h02, 8'hFD, 10, "w8 div -7/2");
    chk("w8 idle", 64'(bsy8), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
